if_id_stage: RTL and testbench
==============================

# if_id_stage

Fetch-to-decode pipeline stage. Accepts fetched instruction words with their PC over a valid/ready handshake and registers them in a two-entry skid buffer. It splits the held instruction into MIPS fields and presents them to the decode stage. Its `out_imm` and `out_shamt` drive the immediate/shift-amount extender directly, and `out_rs`/`out_rt`/`out_rd` drive the register file.

## Interface
- `INSTR_W`, 32: instruction word width. Fixed at 32; other values are unsupported.
- `PC_W`, 32: PC width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: stage can accept a word; registered.
- `in_instr` input INSTR_W: fetched instruction.
- `in_pc` input PC_W: PC of `in_instr`.
- `flush` input 1: discard all held and incoming words (branch/jump redirect).
- `out_valid` output 1: decoded instruction present.
- `out_ready` input 1: downstream accepts.
- `out_pc` output PC_W: PC of the presented instruction.
- `out_opcode` output 6: bits [31:26].
- `out_rs`, `out_rt`, `out_rd` output 5 each: bits [25:21], [20:16], [15:11].
- `out_shamt` output 5: bits [10:6].
- `out_funct` output 6: bits [5:0].
- `out_imm` output 16: bits [15:0].
- `out_jaddr` output 26: bits [25:0].
- `out_fmt` output 2: 0 = R, 1 = I, 2 = J; 3 is never driven.

## Operation
- Storage: a main register (feeds outputs) and a skid register, each holding {valid, instr, pc, fmt}.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Transfers:
  - Accept occurs when `in_valid && in_ready`.
  - Release occurs when `out_valid && out_ready`.
- Transitions (no flush):
  - EMPTY + accept goes to ONE.
  - ONE + accept without release goes to TWO; the word goes to skid.
  - ONE + accept with release stays ONE; main reloads from input.
  - ONE + release without accept goes to EMPTY.
  - TWO + release goes to ONE; skid moves to main. No accept is possible in TWO.
- `in_ready` is registered and equals NOT(next state is TWO).
- `fmt` is computed at capture:
  - opcode 0 gives R.
  - opcode 2 or 3 gives J.
  - everything else gives I.
- Fields are pure slices of the main register's instruction; no sign extension in this block.
- Flush:
  - Next state is EMPTY and `in_ready` is 1 next cycle.
  - A word offered in the flush cycle is dropped, not accepted.
  - A release in the flush cycle still completes downstream.
- Reset:
  - State EMPTY; `out_valid` 0; `in_ready` 1.
  - All field outputs and `out_pc` are 0.
  - Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- While `out_valid && !out_ready`, every output field is held stable.
- When `out_valid` is 0, fields hold their last value; downstream must ignore them.

## Timing
- Latency: 1 cycle from accept edge to `out_valid`.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- Back-pressure:
  - The stage absorbs exactly one extra word after `out_ready` drops.
  - `in_ready` falls the cycle after the second word is captured.
  - `in_ready` rises the cycle after the first release from TWO.
- No combinational path from `out_ready` to `in_ready`, or from inputs to outputs.

## Configuration
- `IF_ID_BUBBLE_COUNT_EN` defined:
  - Adds output `bubble_cnt` (16 bits), reset to 0.
  - Increments each cycle with `out_ready && !out_valid`.
  - Saturates at 16'hFFFF; clears on `flush`.
- Undefined: no port and no counter logic.

## Structure
- Shared package `if_id_pkg` holds:
  - the `fmt_t` enum (FMT_R, FMT_I, FMT_J);
  - the `state_t` enum (EMPTY, ONE, TWO);
  - the opcode constants OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03;
  - the packed struct `if_id_entry_t` {valid, instr, pc, fmt}.
- One sub-module: `instr_fmt_classify`, a combinational opcode-to-`fmt_t` decoder instantiated once at the input.

## Test plan
- Reset, then `in_instr`=32'h2008FFFC, `in_pc`=32'h0000_0040, `out_ready`=1:
  - next cycle `out_valid`=1, opcode 6'h08, rs 0, rt 8, `out_imm` 16'hFFFC, fmt I, `out_pc` 32'h40.
- `in_instr`=32'h00094080:
  - opcode 0, rt 9, rd 8, shamt 2, funct 0, fmt R.
  - 32'h08000010 gives opcode 2, jaddr 26'h10, fmt J.
- Back-pressure:
  - `out_ready`=0 while offering 3 back-to-back words.
  - Words 1 and 2 are accepted; `in_ready`=0 from the cycle after word 2; word 3 is held upstream.
  - `out_ready`=1 then yields words 1, 2, 3 in order with no loss or duplication.
- Flush in state TWO with `in_valid`=1:
  - next cycle `out_valid`=0 and `in_ready`=1; the offered word never appears.
- Async reset mid-stream in TWO:
  - `out_valid`=0, `in_ready`=1, all fields 0 before the next clock edge.
- With `IF_ID_BUBBLE_COUNT_EN`: 5 idle cycles with `out_ready`=1 give `bubble_cnt`=5; flush gives 0.

Source files
------------

// File: rtl/if_id_pkg.sv
// Shared types for the fetch-to-decode stage: formats, FSM states,
// opcode constants and the buffered entry layout.
package if_id_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        fmt_t            fmt;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_stage_classify.sv
// Opcode to instruction-format decoder, evaluated on the incoming
// word so the format is stored alongside it.
module instr_fmt_classify
    import if_id_pkg::*;
(
    input  logic [5:0] opcode,
    output fmt_t       fmt
);

    always_comb begin
        fmt = FMT_I;
        unique case (1'b1)
            (opcode == OP_RTYPE):                   fmt = FMT_R;
            (opcode == OP_J) || (opcode == OP_JAL): fmt = FMT_J;
            default:                                fmt = FMT_I;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode stage: two-entry skid buffer plus MIPS field split.
// Optional IF_ID_BUBBLE_COUNT_EN adds a saturating bubble counter.
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [15:0]        out_imm,
    output logic [25:0]        out_jaddr,
`ifdef IF_ID_BUBBLE_COUNT_EN
    output logic [15:0]        bubble_cnt,
`endif
    output logic [1:0]         out_fmt
);

    state_t       state;
    if_id_entry_t main_q;
    if_id_entry_t skid_q;
    if_id_entry_t cap;
    fmt_t         fmt_in;
    logic         accept;
    logic         release_w;

    instr_fmt_classify u_classify (
        .opcode (in_instr[31:26]),
        .fmt    (fmt_in)
    );

    assign accept    = in_valid && in_ready;
    assign release_w = out_valid && out_ready;

    always_comb begin
        cap.valid = 1'b1;
        cap.instr = in_instr;
        cap.pc    = in_pc;
        cap.fmt   = fmt_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b1;
        end else if (flush) begin
            // Payload is kept; only the valid bits are dropped.
            state        <= EMPTY;
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= cap;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !release_w) begin
                        skid_q   <= cap;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (accept) begin
                        main_q <= cap;
                    end else if (release_w) begin
                        main_q.valid <= 1'b0;
                        state        <= EMPTY;
                    end
                end
                TWO: begin
                    if (release_w) begin
                        main_q       <= skid_q;
                        skid_q.valid <= 1'b0;
                        state        <= ONE;
                        in_ready     <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    main_q   <= '0;
                    skid_q   <= '0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid  = main_q.valid;
    assign out_pc     = main_q.pc;
    assign out_opcode = main_q.instr[31:26];
    assign out_rs     = main_q.instr[25:21];
    assign out_rt     = main_q.instr[20:16];
    assign out_rd     = main_q.instr[15:11];
    assign out_shamt  = main_q.instr[10:6];
    assign out_funct  = main_q.instr[5:0];
    assign out_imm    = main_q.instr[15:0];
    assign out_jaddr  = main_q.instr[25:0];
    assign out_fmt    = main_q.fmt;

`ifdef IF_ID_BUBBLE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (flush) begin
            bubble_cnt <= '0;
        end else if (out_ready && !out_valid && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode, back-pressure, flush,
// async reset and (when enabled) the bubble counter.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [15:0] out_imm;
    logic [25:0] out_jaddr;
    logic [1:0]  out_fmt;
`ifdef IF_ID_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    if_id_stage #(.INSTR_W(32), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_funct  (out_funct),
        .out_imm    (out_imm),
        .out_jaddr  (out_jaddr),
`ifdef IF_ID_BUBBLE_COUNT_EN
        .bubble_cnt (bubble_cnt),
`endif
        .out_fmt    (out_fmt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = p;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_pc", out_pc, 0);
        chk("rst_op", out_opcode, 0);
        chk("rst_imm", out_imm, 0);

        // I-type, R-type and J-type back to back
        offer(32'h2008FFFC, 32'h40);
        tick();
        chk("i_valid", out_valid, 1);
        chk("i_op", out_opcode, 6'h08);
        chk("i_rs", out_rs, 0);
        chk("i_rt", out_rt, 8);
        chk("i_imm", out_imm, 16'hFFFC);
        chk("i_fmt", out_fmt, 1);
        chk("i_pc", out_pc, 32'h40);
        offer(32'h00094080, 32'h44);
        tick();
        chk("r_op", out_opcode, 0);
        chk("r_rt", out_rt, 9);
        chk("r_rd", out_rd, 8);
        chk("r_shamt", out_shamt, 2);
        chk("r_funct", out_funct, 0);
        chk("r_fmt", out_fmt, 0);
        chk("r_pc", out_pc, 32'h44);
        offer(32'h08000010, 32'h48);
        tick();
        chk("j_op", out_opcode, 2);
        chk("j_addr", out_jaddr, 26'h10);
        chk("j_fmt", out_fmt, 2);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // back-pressure: three words, downstream stalled
        out_ready = 1'b0;
        offer(32'h20010001, 32'h100);
        tick();
        chk("bp1_valid", out_valid, 1);
        chk("bp1_ready", in_ready, 1);
        offer(32'h20020002, 32'h104);
        tick();
        chk("bp2_ready", in_ready, 0);
        chk("bp2_pc", out_pc, 32'h100);
        offer(32'h20030003, 32'h108);
        tick();
        chk("bp3_ready", in_ready, 0);
        chk("bp3_pc", out_pc, 32'h100);
        chk("bp3_imm", out_imm, 16'h0001);
        tick();
        chk("bp3b_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        tick();
        chk("bp_w2_pc", out_pc, 32'h104);
        chk("bp_w2_imm", out_imm, 16'h0002);
        chk("bp_w2_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_w3_pc", out_pc, 32'h108);
        chk("bp_w3_imm", out_imm, 16'h0003);
        chk("bp_w3_valid", out_valid, 1);
        tick();
        chk("bp_end_valid", out_valid, 0);

        // flush while holding two words, with a third offered
        out_ready = 1'b0;
        offer(32'h20040004, 32'h200);
        tick();
        offer(32'h20050005, 32'h204);
        tick();
        chk("fl_two", in_ready, 0);
        offer(32'h20060006, 32'h208);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_gone", out_valid, 0);
        tick();
        chk("fl_gone2", out_valid, 0);

        // async reset in TWO, checked before the next edge
        out_ready = 1'b0;
        offer(32'h2007ABCD, 32'h300);
        tick();
        offer(32'h2008BCDE, 32'h304);
        tick();
        in_valid = 1'b0;
        chk("ar_two", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        chk("ar_op", out_opcode, 0);
        chk("ar_rt", out_rt, 0);
        chk("ar_imm", out_imm, 0);
        chk("ar_jaddr", out_jaddr, 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;

`ifdef IF_ID_BUBBLE_COUNT_EN
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("bc_clr", bubble_cnt, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("bc_five", bubble_cnt, 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("bc_flush", bubble_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
